// File: rtl/noise_env_shaper.sv
// noise_env_shaper: sample-rate divider for the noise LFSR, one-pole low-pass
// filter, gated attack/sustain/release envelope and output gain stage.
// One shaped signed 16-bit sample per DIV clocks, marked by sample_valid.
module noise_env_shaper #(
    parameter int DIV   = 64,  // clocks per sample period, 4..65535
    parameter int SHIFT = 3    // filter coefficient 2^-SHIFT, 0..8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [7:0]  attack_step,
    input  logic [7:0]  release_step,
    input  logic [15:0] noise_in,
    output logic        noise_en,
    output logic [7:0]  env,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

    logic [15:0]        cnt;
    logic               cap;        // LFSR word is fresh: filter and envelope step
    logic               upd;        // y and env are fresh: output stage updates
    logic signed [15:0] y;
    logic signed [15:0] y_next;
    logic signed [16:0] diff;
    logic signed [16:0] diff_sh;
    logic signed [24:0] prod;
    logic [8:0]         env_sum;
    logic [8:0]         env_dif;
    logic [7:0]         env_next;
    state_t             state;
    state_t             state_next;

    // Divider and pipeline strobes: cap follows noise_en, upd follows cap.
    // NOTE: every register uses non-blocking assignments so all stages see
    // the values from before the edge, which is what keeps cap/upd aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            cap <= 1'b0;
            upd <= 1'b0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 16'd1;
            cap <= noise_en;
            upd <= cap;
        end
    end

    // Filter update: the difference is widened to 17 bits so it cannot wrap;
    // the shifted step keeps the result between y and noise_in.
    always_comb begin
        diff    = $signed({noise_in[15], noise_in}) - $signed({y[15], y});
        diff_sh = diff >>> SHIFT;
        y_next  = y + diff_sh[15:0];
    end

    // State register, filter state and envelope level, all stepped in cap cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            env   <= '0;
            y     <= '0;
        end else if (cap) begin
            state <= state_next;
            env   <= env_next;
            y     <= y_next;
        end
    end

    // Next-state and next-envelope decode, using 9-bit sums for saturation.
    // NOTE: both results get a default first so no path leaves them unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        env_next   = env;
        env_sum    = {1'b0, env} + {1'b0, attack_step};
        env_dif    = {1'b0, env} - {1'b0, release_step};
        case (state)
            IDLE: begin
                env_next = 8'd0;
                if (gate) state_next = ATTACK;
            end
            ATTACK: begin
                if (!gate) begin
                    state_next = RELEASE;
                end else begin
                    env_next = env_sum[8] ? 8'd255 : env_sum[7:0];
                    if (env_sum[8] || env_sum[7:0] == 8'd255) state_next = SUSTAIN;
                end
            end
            SUSTAIN: begin
                env_next = 8'd255;
                if (!gate) state_next = RELEASE;
            end
            RELEASE: begin
                if (gate) begin
                    state_next = ATTACK;
                end else begin
                    env_next = env_dif[8] ? 8'd0 : env_dif[7:0];
                    if (env_dif[8] || env_dif[7:0] == 8'd0) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from registered state and counter.
    always_comb begin
        noise_en = (cnt == CNT_LAST);
        busy     = (state != IDLE);
        prod     = y * $signed({1'b0, env});
    end

    // Output stage: gain applied the cycle after cap, strobed for one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= upd;
            if (upd) sample_out <= prod[23:8];
        end
    end

endmodule

// File: tb/tb_noise_env_shaper.sv
// Testbench for noise_env_shaper: divider timing, a table of per-sample
// vectors checked through a scoreboard queue, and a mid-operation reset.
// Two instances share stimulus: SHIFT=3 (a) and SHIFT=0 (b), both DIV=8.
module tb_noise_env_shaper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gate = 1'b0;
    logic [7:0]  attack_step = '0;
    logic [7:0]  release_step = '0;
    logic [15:0] noise_in = '0;

    logic        noise_en_a, noise_en_b;
    logic [7:0]  env_a, env_b;
    logic [15:0] sample_a, sample_b;
    logic        valid_a, valid_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        gate;
        logic [7:0]  atk;
        logic [7:0]  rel;
        logic [15:0] noise;
        logic [7:0]  env;
        logic [15:0] sa;
        logic [15:0] sb;
        logic        busy;
    } vec_t;

    vec_t vecs[20];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    noise_env_shaper #(.DIV(8), .SHIFT(3)) u_dut_a (
        .clk(clk), .reset(reset), .gate(gate), .attack_step(attack_step),
        .release_step(release_step), .noise_in(noise_in), .noise_en(noise_en_a),
        .env(env_a), .sample_out(sample_a), .sample_valid(valid_a), .busy(busy_a)
    );

    noise_env_shaper #(.DIV(8), .SHIFT(0)) u_dut_b (
        .clk(clk), .reset(reset), .gate(gate), .attack_step(attack_step),
        .release_step(release_step), .noise_in(noise_in), .noise_en(noise_en_b),
        .env(env_b), .sample_out(sample_b), .sample_valid(valid_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_noise_en(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (noise_en_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic ok;
        vec_t e;

        // rst gate atk rel noise | env sample_a sample_b busy
        vecs[0]  = '{1'b1, 1'b1, 8'd255, 8'd0,  16'h7FFF, 8'd0,   16'd0,     16'd0,     1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'd255, 8'd0,  16'h7FFF, 8'd255, 16'd7649,  16'd32639, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 8'd255, 8'd0,  16'h7FFF, 8'd255, 16'd10772, 16'd32639, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'd255, 8'd0,  16'h8000, 8'd255, 16'd5346,  16'h8080,  1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'd100, 8'd60, 16'h4000, 8'd0,   16'd0,     16'd0,     1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'd100, 8'd60, 16'h4000, 8'd100, 16'd1500,  16'd6400,  1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'd100, 8'd60, 16'h4000, 8'd200, 16'd4225,  16'd12800, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'd100, 8'd60, 16'h4000, 8'd255, 16'd6753,  16'd16320, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd255, 16'd6753,  16'd6753,  1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd195, 16'd5164,  16'd5164,  1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd135, 16'd3575,  16'd3575,  1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'd100, 8'd60, 16'h1A7C, 8'd135, 16'd3575,  16'd3575,  1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'd100, 8'd60, 16'h1A7C, 8'd235, 16'd6223,  16'd6223,  1'b1};
        vecs[13] = '{1'b0, 1'b1, 8'd100, 8'd60, 16'h1A7C, 8'd255, 16'd6753,  16'd6753,  1'b1};
        vecs[14] = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd255, 16'd6753,  16'd6753,  1'b1};
        vecs[15] = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd195, 16'd5164,  16'd5164,  1'b1};
        vecs[16] = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd135, 16'd3575,  16'd3575,  1'b1};
        vecs[17] = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd75,  16'd1986,  16'd1986,  1'b1};
        vecs[18] = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd15,  16'd397,   16'd397,   1'b1};
        vecs[19] = '{1'b0, 1'b0, 8'd100, 8'd60, 16'h1A7C, 8'd0,   16'd0,     16'd0,     1'b0};

        // Divider timing and idle outputs straight out of reset.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 24; c++) begin
            check($sformatf("div_noise_en_c%0d", c), 32'(noise_en_a), 32'((c % 8) == 7));
            check($sformatf("div_valid_c%0d", c), 32'(valid_a), 32'(c == 10 || c == 18));
            check($sformatf("idle_busy_c%0d", c), 32'(busy_a), 32'd0);
            check($sformatf("idle_env_c%0d", c), 32'(env_a), 32'd0);
            check($sformatf("idle_sample_c%0d", c), 32'(sample_a), 32'd0);
            @(negedge clk);
        end

        // Table of per-sample vectors through the scoreboard queue.
        for (int i = 0; i < 20; i++) begin
            gate         = vecs[i].gate;
            attack_step  = vecs[i].atk;
            release_step = vecs[i].rel;
            noise_in     = vecs[i].noise;
            if (vecs[i].rst) apply_reset();
            exp_q.push_back(vecs[i]);
            wait_valid(ok);
            check($sformatf("v%0d_valid_seen", i), 32'(ok), 32'd1);
            e = exp_q.pop_front();
            check($sformatf("v%0d_valid_b", i), 32'(valid_b), 32'd1);
            check($sformatf("v%0d_env", i), 32'(env_a), 32'(e.env));
            check($sformatf("v%0d_env_b", i), 32'(env_b), 32'(e.env));
            check($sformatf("v%0d_sample_a", i), 32'(sample_a), 32'(e.sa));
            check($sformatf("v%0d_sample_b", i), 32'(sample_b), 32'(e.sb));
            check($sformatf("v%0d_busy", i), 32'(busy_a), 32'(e.busy));
        end

        // Mid-operation reset: drive up to SUSTAIN with a full-negative word,
        // then reset two cycles after a noise_en and expect the sample dropped.
        gate        = 1'b1;
        attack_step = 8'd255;
        noise_in    = 16'h8000;
        repeat (3) begin
            wait_noise_en(ok);
            check("mid_noise_en_seen", 32'(ok), 32'd1);
        end
        check("mid_pre_env", 32'(env_a), 32'd255);
        check("mid_pre_busy", 32'(busy_a), 32'd1);
        check("mid_pre_sample_b", 32'(sample_b), 32'h8080);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_env", 32'(env_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_sample_a", 32'(sample_a), 32'd0);
        check("mid_rst_sample_b", 32'(sample_b), 32'd0);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("mid_restart_noise_en_c%0d", c), 32'(noise_en_a), 32'(c == 7));
            check($sformatf("mid_restart_valid_c%0d", c), 32'(valid_a), 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
